reg_select_unit: RTL
====================

# reg_select_unit

Parametrised register-select and decode unit for the datapath control path. Captures the instruction register, extracts the Ra/Rb/Rc fields, and decodes the strobed field into one-hot register-file write/read enables with base-address-zero handling. Adds a per-register busy scoreboard so outstanding memory loads stall dependent register accesses, plus a sign-extended C field for the immediate path. Sits between the control unit and the register file/bus multiplexer.

## Interface
- NREGS, 16: number of general registers (power of two)
- REG_W, 4: register index width, log2(NREGS)
- IR_W, 32: instruction width
- RA_LSB, 23: LSB of the Ra field (field is IR[RA_LSB+REG_W-1:RA_LSB])
- RB_LSB, 19: LSB of the Rb field
- RC_LSB, 15: LSB of the Rc field
- C_W, 19: width of the C immediate (IR[C_W-1:0]), sign bit IR[C_W-1]

- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- ir_in  in  IR_W  instruction word from the bus
- ir_load  in  1  capture ir_in into ir_q on the next edge
- gra, grb, grc  in  1  select the Ra/Rb/Rc field
- rin, rout, baout  in  1  register write, register read, base-address read
- lock  in  1  mark the selected register busy (load issued)
- release  in  1  clear busy for release_idx (load data returned)
- release_idx  in  REG_W  register being released
- ir_q  out  IR_W  captured instruction
- r_in  out  NREGS  one-hot register write enables
- r_out  out  NREGS  one-hot register read enables
- zero_out  out  1  drive constant 0 onto the bus (baout with R0)
- c_sign_ext  out  IR_W  IR[C_W-1:0] sign-extended to IR_W
- busy  out  NREGS  scoreboard state
- stall  out  1  selected access blocked by a busy register
- sel_err  out  1  sticky: more than one of gra/grb/grc seen high

## Operation
- Selection priority gra > grb > grc; sel = chosen field of ir_q; sel_valid = gra|grb|grc.
- hit = busy[sel] & ~(release & release_idx==sel) (same-cycle release bypasses).
- stall = sel_valid & (rin|rout|baout) & hit.
- r_in = onehot(sel) when rin & sel_valid & ~stall, else 0.
- r_out = onehot(sel) when (rout | (baout & sel!=0)) & sel_valid & ~stall, else 0.
- zero_out = baout & sel_valid & sel==0 & ~stall; r_out stays 0 in that case.
- rin and rout both high: both vectors carry the same one-hot.
- No strobe high: r_in, r_out, zero_out, stall all 0.
- c_sign_ext = {(IR_W-C_W){ir_q[C_W-1]}, ir_q[C_W-1:0]}.
- Scoreboard update per edge: release clears busy[release_idx] first; then lock & sel_valid & ~stall & sel!=0 sets busy[sel]. Lock and release on same index same cycle → busy stays 1. Release of an idle register: no effect. Lock of R0 ignored. Lock while stalled ignored.
- sel_err set on any edge with two or more of gra/grb/grc high; cleared only by reset.

## Timing
- r_in, r_out, zero_out, stall, c_sign_ext: combinational from ir_q, strobes, busy, release inputs; zero-cycle latency.
- ir_q updates on the edge where ir_load=1; decode reflects the new IR from the following cycle.
- busy updates one edge after lock/release; stall clears in the same cycle as a matching release (bypass).
- Reset (clear=0, async): ir_q=0, busy=0, sel_err=0; hence c_sign_ext=0, stall=0, and r_in/r_out/zero_out=0 with no strobes. Reset during an outstanding load drops all busy bits; a later release for that register has no effect.

## Test plan
- Reset, load ir_in=0x0A8C0000 (Ra=5, Rb=1, Rc=8), gra+rin -> r_in=0x0020; grb+rout -> r_out=0x0002; grc+rout -> r_out=0x0100; zero_out=0.
- Ra=0 with gra+baout -> r_out=0, zero_out=1; Ra=3 with gra+baout -> r_out=0x0008, zero_out=0.
- C field 0x40000 (bit 18 set) -> c_sign_ext=0xFFFC0000; 0x3FFFF -> 0x0003FFFF.
- gra+lock on Ra=5 -> busy=0x0020 next cycle; gra+rout -> stall=1, r_out=0; assert release, release_idx=5 same cycle -> stall=0, r_out=0x0020; busy=0 after edge.
- lock and release both targeting R7 same edge -> busy[7]=1; lock on R0 -> busy unchanged; release on idle R2 -> unchanged.
- gra+grb together -> Ra decoded, sel_err=1 after edge and stays 1 until clear=0; async clear mid-lock -> busy=0 immediately.

Source files
------------

// File: rtl/reg_select_unit.sv
// Register-select and decode unit: captures the instruction word, picks the
// Ra/Rb/Rc field by strobe priority, and turns it into one-hot register-file
// write/read enables. A per-register busy scoreboard stalls accesses to
// registers with an outstanding load. The load-return strobe is named
// release_en because "release" is a reserved word in SystemVerilog.
module reg_select_unit #(
  parameter int NREGS  = 16,
  parameter int REG_W  = 4,
  parameter int IR_W   = 32,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int C_W    = 19
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [IR_W-1:0]   ir_in,
  input  logic              ir_load,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              rin,
  input  logic              rout,
  input  logic              baout,
  input  logic              lock,
  input  logic              release_en,
  input  logic [REG_W-1:0]  release_idx,
  output logic [IR_W-1:0]   ir_q,
  output logic [NREGS-1:0]  r_in,
  output logic [NREGS-1:0]  r_out,
  output logic              zero_out,
  output logic [IR_W-1:0]   c_sign_ext,
  output logic [NREGS-1:0]  busy,
  output logic              stall,
  output logic              sel_err
);

  logic [IR_W-1:0]  ir_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             sel_err_q, sel_err_d;

  logic [REG_W-1:0] sel;
  logic             sel_valid;
  logic             sel_zero;
  logic             hit;
  logic [NREGS-1:0] sel_onehot;

  // Field select with gra > grb > grc priority.
  always_comb begin
    sel       = '0;
    sel_valid = gra | grb | grc;
    if (gra)      sel = ir_q[RA_LSB +: REG_W];
    else if (grb) sel = ir_q[RB_LSB +: REG_W];
    else if (grc) sel = ir_q[RC_LSB +: REG_W];
  end

  // Decode: busy hit with same-cycle release bypass, stall and one-hot enables.
  always_comb begin
    sel_zero   = (sel == '0);
    sel_onehot = {{(NREGS-1){1'b0}}, 1'b1} << sel;
    hit        = busy_q[sel] & ~(release_en & (release_idx == sel));
    stall      = sel_valid & (rin | rout | baout) & hit;
    r_in       = (rin & sel_valid & ~stall) ? sel_onehot : '0;
    r_out      = ((rout | (baout & ~sel_zero)) & sel_valid & ~stall) ? sel_onehot : '0;
    zero_out   = baout & sel_valid & sel_zero & ~stall;
    c_sign_ext = {{(IR_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
  end

  // Next-state for IR, scoreboard (release first, then lock wins) and sticky error.
  always_comb begin
    ir_d = ir_load ? ir_in : ir_q;
    busy_d = busy_q;
    if (release_en) busy_d[release_idx] = 1'b0;
    if (lock & sel_valid & ~stall & ~sel_zero) busy_d[sel] = 1'b1;
    sel_err_d = sel_err_q | (gra & grb) | (gra & grc) | (grb & grc);
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ir_q      <= '0;
      busy_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign busy    = busy_q;
  assign sel_err = sel_err_q;

endmodule
